// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VESA 1024x768@60 timing constants and shared pixel types
package vga_pkg;

  localparam int VGA_H_ACTIVE   = 1024;
  localparam int VGA_H_FP       = 24;
  localparam int VGA_H_SYNC     = 136;
  localparam int VGA_H_BP       = 160;
  localparam int VGA_V_ACTIVE   = 768;
  localparam int VGA_V_FP       = 3;
  localparam int VGA_V_SYNC     = 6;
  localparam int VGA_V_BP       = 29;
  localparam logic VGA_SYNC_POL = 1'b0;
  localparam int VGA_SYNC_DELAY = 2;

  // Shared with the world-map scaler so both agree on the drawable area.
  localparam int SCREEN_MARGIN  = 128;
  localparam int WORLD_SCALE    = 6;

  localparam int COORD_W        = 12;
  localparam int COORD_LIMIT    = 1 << COORD_W;

  typedef logic [COORD_W-1:0] pixel_coord_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - pixel enable in, coordinates and sync flags out
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic         pix_en;
  pixel_coord_t pixel_column;
  pixel_coord_t pixel_row;
  logic         video_on;
  logic         horiz_sync;
  logic         vert_sync;
  logic         line_start;
  logic         frame_start;
  logic         video_on_d;
  logic         horiz_sync_d;
  logic         vert_sync_d;

  modport master (
    input  pix_en,
    output pixel_column, pixel_row, video_on, horiz_sync, vert_sync,
           line_start, frame_start, video_on_d, horiz_sync_d, vert_sync_d
  );

  modport slave (
    output pix_en,
    input  pixel_column, pixel_row, video_on, horiz_sync, vert_sync,
           line_start, frame_start, video_on_d, horiz_sync_d, vert_sync_d
  );

endinterface

// File: rtl/vga_sync_delay.sv
// rtl/vga_sync_delay.sv - enabled N-stage shift register with per-bit reset value
module vga_sync_delay #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = &{1'b0, clk, reset_n, i_en};
      assign o_q      = i_d;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
        end else if (i_en) begin
          r_stage[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel/line counters with registered sync, blank and pulse flags
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE   = VGA_H_ACTIVE,
  parameter int   H_FP       = VGA_H_FP,
  parameter int   H_SYNC     = VGA_H_SYNC,
  parameter int   H_BP       = VGA_H_BP,
  parameter int   V_ACTIVE   = VGA_V_ACTIVE,
  parameter int   V_FP       = VGA_V_FP,
  parameter int   V_SYNC     = VGA_V_SYNC,
  parameter int   V_BP       = VGA_V_BP,
  parameter logic SYNC_POL   = VGA_SYNC_POL,
  parameter int   SYNC_DELAY = VGA_SYNC_DELAY
) (
  input logic               clk,
  input logic               reset_n,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam pixel_coord_t H_LAST   = pixel_coord_t'(H_TOTAL - 1);
  localparam pixel_coord_t V_LAST   = pixel_coord_t'(V_TOTAL - 1);
  localparam pixel_coord_t H_VIS    = pixel_coord_t'(H_ACTIVE);
  localparam pixel_coord_t V_VIS    = pixel_coord_t'(V_ACTIVE);
  localparam pixel_coord_t HS_START = pixel_coord_t'(H_ACTIVE + H_FP);
  localparam pixel_coord_t HS_END   = pixel_coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam pixel_coord_t VS_START = pixel_coord_t'(V_ACTIVE + V_FP);
  localparam pixel_coord_t VS_END   = pixel_coord_t'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_size_check
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 12-bit coordinate range");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_delay_check
      $error("vga_timing_gen: SYNC_DELAY must be 0..7");
    end
  endgenerate

  pixel_coord_t r_col, r_row;
  pixel_coord_t w_col_nxt, w_row_nxt;
  logic         w_col_wrap;
  logic         r_video_on, r_hsync, r_vsync, r_line_start, r_frame_start;
  logic         w_video_on_nxt, w_hsync_nxt, w_vsync_nxt, w_line_start_nxt, w_frame_start_nxt;
  logic [2:0]   w_delayed;

  // Flags decode the next count so they line up with the coordinates they describe.
  always_comb begin
    w_col_wrap = (r_col == H_LAST);
    w_col_nxt  = w_col_wrap ? '0 : r_col + pixel_coord_t'(1);
    w_row_nxt  = r_row;
    if (w_col_wrap) begin
      w_row_nxt = (r_row == V_LAST) ? '0 : r_row + pixel_coord_t'(1);
    end
    w_video_on_nxt    = (w_col_nxt < H_VIS) && (w_row_nxt < V_VIS);
    w_hsync_nxt       = ((w_col_nxt >= HS_START) && (w_col_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
    w_vsync_nxt       = ((w_row_nxt >= VS_START) && (w_row_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
    w_line_start_nxt  = (w_col_nxt == '0);
    w_frame_start_nxt = w_line_start_nxt && (w_row_nxt == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col         <= H_LAST;
      r_row         <= V_LAST;
      r_video_on    <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (vga.pix_en) begin
      r_col         <= w_col_nxt;
      r_row         <= w_row_nxt;
      r_video_on    <= w_video_on_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_line_start  <= w_line_start_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  vga_sync_delay #(
    .WIDTH   (3),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL ({1'b0, ~SYNC_POL, ~SYNC_POL})
  ) u_sync_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (vga.pix_en),
    .i_d     ({r_video_on, r_hsync, r_vsync}),
    .o_q     (w_delayed)
  );

  assign vga.pixel_column = r_col;
  assign vga.pixel_row    = r_row;
  assign vga.video_on     = r_video_on;
  assign vga.horiz_sync   = r_hsync;
  assign vga.vert_sync    = r_vsync;
  assign vga.line_start   = r_line_start;
  assign vga.frame_start  = r_frame_start;
  assign vga.video_on_d   = w_delayed[2];
  assign vga.horiz_sync_d = w_delayed[1];
  assign vga.vert_sync_d  = w_delayed[0];

endmodule
